tally_2d_ctrl: RTL and testbench
================================

# tally_2d_ctrl

Frame-level sequencer that streams a 2-D bit matrix, one 12-bit row per transfer, through a single 1-D ones-tally datapath. It accumulates the total ones count for the frame and tracks the row with the most ones. It sits between a row source (memory reader or testbench driver) and any consumer of per-frame population statistics.

## Interface
- Clock is `CLK`; reset is `RST`, synchronous and active-high.
- Parameters:
- ROWS, default 12: rows per frame. Legal range 2..256.
- Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  begin a frame. Sampled only in IDLE.
- ROW_VALID  in  1  ROW_DATA is valid.
- ROW_DATA  in  12  matrix row to tally.
- ROW_READY  out  1  controller accepts a row this cycle.
- BUSY  out  1  high in ACCEPT and REPORT.
- DONE  out  1  one-cycle pulse; results final.
- TOTAL  out  $clog2(ROWS*12+1)  sum of ones over the frame.
- MAX_COUNT  out  4  highest per-row count in the frame.
- MAX_ROW  out  $clog2(ROWS)  index of the first row reaching MAX_COUNT.

## Operation
- FSM states:
  - IDLE: START → ACCEPT. On this transition, clear TOTAL, MAX_COUNT, MAX_ROW and the row index to 0.
  - ACCEPT: ROW_READY=1. A row is accepted on ROW_VALID && ROW_READY. Each accept:
    - TOTAL += tally(ROW_DATA).
    - If tally > MAX_COUNT (strict), load MAX_COUNT and MAX_ROW from that row.
    - Row index increments.
    - The accept with index == ROWS-1 → REPORT.
  - REPORT: DONE=1 for exactly one cycle, then → IDLE unconditionally.
- ROW_READY depends only on state, never on ROW_VALID.
- START is ignored in ACCEPT and REPORT. It has no queuing effect.
- ROW_VALID/ROW_DATA outside ACCEPT are ignored.
- Ties for the maximum go to the lowest index. An all-zero frame gives MAX_COUNT=0, MAX_ROW=0.
- Arithmetic:
  - Row count is 4 bits (0..12), zero-extended to the TOTAL width before the add.
  - TOTAL cannot overflow by construction.
  - The row index wraps to 0 only via the IDLE→ACCEPT clear.
- TOTAL, MAX_COUNT and MAX_ROW update live during ACCEPT. They are final at DONE and held through IDLE until the next START is accepted.

## Timing
- Reset values: state IDLE; ROW_READY, BUSY, DONE, TOTAL, MAX_COUNT, MAX_ROW, row index all 0.
- RST in any state, including mid-frame, discards the partial frame and returns all of the above to reset values on the next edge. RST has priority over START and row accepts.
- START high at edge t (IDLE) → ROW_READY=1 and BUSY=1 from cycle t+1.
- Tally-to-accumulate is same-cycle: the combinational count feeds the adder, and the result is registered on the accept edge. No pipeline bubble.
- Last row accepted at edge k → DONE=1 in cycle k+1 (REPORT) → IDLE in cycle k+2.
- The earliest next START is sampled at edge k+2.
- Minimum frame duration: ROWS+2 cycles from START to the return to IDLE. ROW_VALID gaps extend ACCEPT one cycle per gap.

## Structure
- Shared package `tally_pkg`:
  - VEC_W=12 and CNT_W=4 constants.
  - `tally_state_e` enum {IDLE, ACCEPT, REPORT}.
- Sub-module: the existing 1-D tally block, instantiated once with `.VECTOR(ROW_DATA)` and `.COUNT(row_count)`. The controller adds no second popcount.
- The FSM, accumulator and max tracker live in `tally_2d_ctrl`.

## Test plan
- Reset: assert RST 2 cycles with random inputs → all outputs 0, ROW_READY=0, START ignored while RST=1.
- ROWS=4, rows 0x000, 0x321, 0x8AC, 0xFFF back-to-back → DONE exactly one cycle after the 4th accept; TOTAL=21, MAX_COUNT=12, MAX_ROW=3; values held until next START.
- ROWS=4, rows 0x00F, 0xF00, 0x0F0, 0x001 → TOTAL=13, MAX_COUNT=4, MAX_ROW=0 (first-tie rule).
- ROWS=4 frame with 3 idle cycles inserted in ROW_VALID, plus START pulsed mid-ACCEPT and during REPORT → same results as the back-to-back case for identical rows; the extra STARTs start no frame.
- ROWS=4: RST after 2 rows accepted → outputs 0. The next frame of 0xFFF ×4 → TOTAL=48, MAX_COUNT=12, MAX_ROW=0.
- ROWS=12, 50 random frames with random ROW_VALID gaps → TOTAL/MAX_COUNT/MAX_ROW match a `$countones` model. DONE count equals frames sent.

Source files
------------

// File: rtl/tally_pkg.sv
// Shared widths and controller state encoding for the 2-D tally slice.
package tally_pkg;

  localparam int VEC_W = 12;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    REPORT
  } tally_state_e;

endpackage

// File: rtl/tally_2d_ctrl_if.sv
// Row-source / statistics-consumer bundle for tally_2d_ctrl.
interface tally_2d_ctrl_if #(
  parameter int ROWS = 12
);
  import tally_pkg::*;

  localparam int TOT_W = $clog2(ROWS * VEC_W + 1);
  localparam int IDX_W = $clog2(ROWS);

  logic             START;
  logic             ROW_VALID;
  logic [VEC_W-1:0] ROW_DATA;
  logic             ROW_READY;
  logic             BUSY;
  logic             DONE;
  logic [TOT_W-1:0] TOTAL;
  logic [CNT_W-1:0] MAX_COUNT;
  logic [IDX_W-1:0] MAX_ROW;

  modport master (
    output START, ROW_VALID, ROW_DATA,
    input  ROW_READY, BUSY, DONE, TOTAL, MAX_COUNT, MAX_ROW
  );

  modport slave (
    input  START, ROW_VALID, ROW_DATA,
    output ROW_READY, BUSY, DONE, TOTAL, MAX_COUNT, MAX_ROW
  );

endinterface

// File: rtl/tally_2d_ctrl_tally_1d.sv
// Combinational ones count of one matrix row.
module tally_1d
  import tally_pkg::*;
(
  input  logic [VEC_W-1:0] VECTOR,
  output logic [CNT_W-1:0] COUNT
);

  always_comb begin
    COUNT = '0;
    for (int unsigned i = 0; i < VEC_W; i++) begin
      COUNT = COUNT + CNT_W'(VECTOR[i]);
    end
  end

endmodule

// File: rtl/tally_2d_ctrl.sv
// Frame sequencer: streams ROWS rows through one tally, accumulating the
// frame total and the first row holding the maximum count.
module tally_2d_ctrl
  import tally_pkg::*;
#(
  parameter int ROWS = 12
) (
  input  logic            CLK,
  input  logic            RST,
  tally_2d_ctrl_if.slave  bus
);

  localparam int TOT_W = $clog2(ROWS * VEC_W + 1);
  localparam int IDX_W = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

  tally_state_e     state;
  logic [CNT_W-1:0] row_count;
  logic [IDX_W-1:0] row_idx;
  logic             row_ready;
  logic             busy;
  logic             done;
  logic [TOT_W-1:0] total;
  logic [CNT_W-1:0] max_count;
  logic [IDX_W-1:0] max_row;

  tally_1d u_tally (
    .VECTOR (bus.ROW_DATA),
    .COUNT  (row_count)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      row_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      total     <= '0;
      max_count <= '0;
      max_row   <= '0;
      row_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.START) begin
            state     <= ACCEPT;
            row_ready <= 1'b1;
            busy      <= 1'b1;
            total     <= '0;
            max_count <= '0;
            max_row   <= '0;
            row_idx   <= '0;
          end
        end
        ACCEPT: begin
          if (bus.ROW_VALID) begin
            total <= total + TOT_W'(row_count);
            // Strict compare keeps the lowest index on ties.
            if (row_count > max_count) begin
              max_count <= row_count;
              max_row   <= row_idx;
            end
            if (row_idx == LAST_IDX) begin
              state     <= REPORT;
              row_ready <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
        end
        REPORT: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          row_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ROW_READY = row_ready;
  assign bus.BUSY      = busy;
  assign bus.DONE      = done;
  assign bus.TOTAL     = total;
  assign bus.MAX_COUNT = max_count;
  assign bus.MAX_ROW   = max_row;

endmodule

// File: tb/tb_tally_2d_ctrl.sv
// Directed table frames on a ROWS=4 instance, random frames on ROWS=12.
module tb_tally_2d_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tally_2d_ctrl_if #(.ROWS(4))  if4 ();
  tally_2d_ctrl_if #(.ROWS(12)) if12 ();

  tally_2d_ctrl #(.ROWS(4))  u4  (.CLK(clk), .RST(rst), .bus(if4));
  tally_2d_ctrl #(.ROWS(12)) u12 (.CLK(clk), .RST(rst), .bus(if12));

  int checks = 0;
  int errors = 0;
  int done12_cnt = 0;

  always @(negedge clk) if (if12.DONE === 1'b1) done12_cnt++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk4_idle_zero(input string tag);
    chk({tag, " ready"}, int'(if4.ROW_READY), 0);
    chk({tag, " busy"},  int'(if4.BUSY), 0);
    chk({tag, " done"},  int'(if4.DONE), 0);
    chk({tag, " total"}, int'(if4.TOTAL), 0);
    chk({tag, " maxc"},  int'(if4.MAX_COUNT), 0);
    chk({tag, " maxr"},  int'(if4.MAX_ROW), 0);
  endtask

  typedef struct {
    logic [11:0] r [4];
    logic [3:0]  gap;
    bit          pulse;
    int          tot;
    int          mc;
    int          mr;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] r0, r1, r2, r3,
                              input logic [3:0] gap, input bit pulse,
                              input int tot, mc, mr);
    vec_t v;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.gap = gap; v.pulse = pulse; v.tot = tot; v.mc = mc; v.mr = mr;
    return v;
  endfunction

  // Drives one ROWS=4 frame starting at a negedge with the DUT in IDLE.
  task automatic frame4(input vec_t v, input int n);
    string t;
    t = $sformatf("v%0d", n);
    if4.START = 1'b1;
    @(negedge clk);
    if4.START = 1'b0;
    chk({t, " ready"}, int'(if4.ROW_READY), 1);
    chk({t, " busy"},  int'(if4.BUSY), 1);
    chk({t, " clr"},   int'(if4.TOTAL), 0);
    for (int i = 0; i < 4; i++) begin
      if (v.gap[i]) begin
        if4.ROW_VALID = 1'b0;
        if4.ROW_DATA  = 12'hFFF;
        if4.START     = v.pulse;
        @(negedge clk);
        chk({t, " gap ready"}, int'(if4.ROW_READY), 1);
        chk({t, " gap done"},  int'(if4.DONE), 0);
      end
      if4.START     = 1'b0;
      if4.ROW_VALID = 1'b1;
      if4.ROW_DATA  = v.r[i];
      @(negedge clk);
    end
    if4.ROW_VALID = 1'b0;
    if4.ROW_DATA  = 12'hFFF;
    if4.START     = v.pulse;
    chk({t, " done"},   int'(if4.DONE), 1);
    chk({t, " rdy0"},   int'(if4.ROW_READY), 0);
    chk({t, " busyR"},  int'(if4.BUSY), 1);
    chk({t, " total"},  int'(if4.TOTAL), v.tot);
    chk({t, " maxc"},   int'(if4.MAX_COUNT), v.mc);
    chk({t, " maxr"},   int'(if4.MAX_ROW), v.mr);
    @(negedge clk);
    if4.START = 1'b0;
    chk({t, " done1"},  int'(if4.DONE), 0);
    chk({t, " idle"},   int'(if4.BUSY), 0);
    @(negedge clk);
    chk({t, " nostart"}, int'(if4.ROW_READY), 0);
    chk({t, " hold"},    int'(if4.TOTAL), v.tot);
    chk({t, " holdm"},   int'(if4.MAX_ROW), v.mr);
  endtask

  task automatic frame12(input int n);
    logic [11:0] row;
    int tot, mc, mr, c;
    tot = 0; mc = 0; mr = 0;
    if12.START = 1'b1;
    @(negedge clk);
    if12.START = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        if12.ROW_VALID = 1'b0;
        if12.START     = 1'($urandom_range(0, 1));
        @(negedge clk);
        if12.START = 1'b0;
      end
      row = 12'($urandom);
      c = $countones(row);
      tot += c;
      if (c > mc) begin mc = c; mr = i; end
      if12.ROW_VALID = 1'b1;
      if12.ROW_DATA  = row;
      @(negedge clk);
    end
    if12.ROW_VALID = 1'b0;
    chk($sformatf("r%0d done", n),  int'(if12.DONE), 1);
    chk($sformatf("r%0d total", n), int'(if12.TOTAL), tot);
    chk($sformatf("r%0d maxc", n),  int'(if12.MAX_COUNT), mc);
    chk($sformatf("r%0d maxr", n),  int'(if12.MAX_ROW), mr);
    @(negedge clk);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = mk(12'h000, 12'h321, 12'h8AC, 12'hFFF, 4'b0000, 1'b0, 21, 12, 3);
    tbl[1] = mk(12'h00F, 12'hF00, 12'h0F0, 12'h001, 4'b0000, 1'b0, 13, 4, 0);
    tbl[2] = mk(12'h000, 12'h321, 12'h8AC, 12'hFFF, 4'b1110, 1'b1, 21, 12, 3);
    tbl[3] = mk(12'h000, 12'h000, 12'h000, 12'h000, 4'b0101, 1'b0, 0, 0, 0);
    tbl[4] = mk(12'h001, 12'h003, 12'h007, 12'h00F, 4'b0000, 1'b1, 10, 4, 3);
    tbl[5] = mk(12'hFFF, 12'h000, 12'hFFF, 12'h7FF, 4'b0010, 1'b0, 35, 12, 0);

    if12.START = 1'b0; if12.ROW_VALID = 1'b0; if12.ROW_DATA = '0;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if4.START     = 1'($urandom_range(0, 1));
      if4.ROW_VALID = 1'($urandom_range(0, 1));
      if4.ROW_DATA  = 12'($urandom);
      @(negedge clk);
      chk4_idle_zero("rst");
    end
    rst = 1'b0;
    if4.START = 1'b0; if4.ROW_VALID = 1'b0; if4.ROW_DATA = '0;
    @(negedge clk);
    chk4_idle_zero("post-rst");

    for (int i = 0; i < 6; i++) frame4(tbl[i], i);

    // Reset mid-frame after two accepted rows.
    if4.START = 1'b1;
    @(negedge clk);
    if4.START = 1'b0;
    if4.ROW_VALID = 1'b1;
    if4.ROW_DATA  = 12'hFFF;
    repeat (2) @(negedge clk);
    chk("mid live total", int'(if4.TOTAL), 24);
    rst = 1'b1;
    if4.START = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if4.START = 1'b0;
    if4.ROW_VALID = 1'b0;
    chk4_idle_zero("mid-rst");
    @(negedge clk);
    chk4_idle_zero("mid-rst idle");
    frame4(mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 4'b0000, 1'b0, 48, 12, 0), 9);

    for (int f = 0; f < 50; f++) frame12(f);
    @(negedge clk);
    chk("done12 count", done12_cnt, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
